// File: rtl/dmem.sv
// Word-organised data memory for the single-cycle MIPS datapath.
// Synchronous full-word write, combinational gated read, async clear of the whole array.
module dmem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] wrdata,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] rddata
);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [AW-1:0] idx;
    logic          unused_addr_hi;

    // Upper address bits are ignored so addresses wrap modulo DEPTH.
    assign idx            = addr[AW-1:0];
    assign unused_addr_hi = ^addr[31:AW];

    always_comb begin
        mem_d = mem_q;
        if (MemWrite) begin
            mem_d[idx] = wrdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rddata = (MemRead && reset_n) ? mem_q[idx] : 32'h0;

endmodule

// File: tb/tb_dmem.sv
// Self-checking bench for dmem: directed timeline, vector table and randomized
// traffic against an array reference model indexed by addr modulo DEPTH.
`timescale 1ns/1ps
module tb_dmem;

    localparam int DEPTH = 256;

    logic        clock;
    logic        reset_n;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] rddata;

    int n_chk;
    int n_err;

    logic [31:0] model [DEPTH];

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    dmem #(.DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .addr     (addr),
        .wrdata   (wrdata),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .rddata   (rddata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic at(input int t);
        #(t - $time);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: rddata=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    function automatic logic [31:0] ref_read(input logic re, input logic [31:0] a);
        return re ? model[a % DEPTH] : 32'h0;
    endfunction

    initial begin
        n_chk = 0;
        n_err = 0;
        clear_model();

        // Directed timeline: 10 ns period, first rising edge at 5 ns.
        reset_n = 1'b0; MemWrite = 1'b0; MemRead = 1'b1; addr = 32'd100; wrdata = 32'h0;
        at(1);  chk("reset_read_100", rddata, 32'h0);
        at(2);  reset_n = 1'b1;
        at(6);  addr = 32'd10; wrdata = 32'd1270033; MemWrite = 1'b1; MemRead = 1'b0;
        at(16); MemWrite = 1'b0; MemRead = 1'b1;
        at(17); chk("write_then_read_10", rddata, 32'h00136111);
        at(26); addr = 32'd100;
        at(27); chk("read_unwritten_100", rddata, 32'h0);
        at(28); addr = 32'd10; MemRead = 1'b0;
        at(29); chk("memread_low_gates", rddata, 32'h0);
        MemRead = 1'b1;
        at(30); chk("memread_rise_no_clock", rddata, 32'h00136111);
        addr = 'x; wrdata = 'x; MemWrite = 1'b0; MemRead = 1'b0;
        at(36); addr = 32'd10; MemRead = 1'b1;
        at(37); chk("x_inputs_no_write", rddata, 32'h00136111);
        addr = 32'd266; wrdata = 32'hDEADBEEF; MemWrite = 1'b1; MemRead = 1'b0;
        at(46); MemWrite = 1'b0; addr = 32'd10; MemRead = 1'b1;
        at(47); chk("alias_266_to_10", rddata, 32'hDEADBEEF);
        addr = 32'd5; wrdata = 32'h11111111; MemWrite = 1'b1; MemRead = 1'b0;
        at(56); MemRead = 1'b1; wrdata = 32'h22222222;
        at(57); chk("rw_same_before_edge", rddata, 32'h11111111);
        at(66); chk("rw_same_after_edge", rddata, 32'h22222222);
        addr = 32'd3; wrdata = 32'hCAFEF00D; MemWrite = 1'b1; MemRead = 1'b0;
        at(76); MemWrite = 1'b0; MemRead = 1'b1;
        at(77); chk("pre_reset_read_3", rddata, 32'hCAFEF00D);
        reset_n = 1'b0;
        at(78); chk("async_reset_clears_3", rddata, 32'h0);
        MemWrite = 1'b1; wrdata = 32'h55555555;
        at(86); chk("reset_rd_zero_re1", rddata, 32'h0);
        MemRead = 1'b0;
        at(87); chk("reset_rd_zero_re0", rddata, 32'h0);
        MemWrite = 1'b0; MemRead = 1'b1;
        at(88); reset_n = 1'b1;
        at(89); chk("write_blocked_in_reset", rddata, 32'h0);
        addr = 32'd5;
        at(90); chk("reset_cleared_5", rddata, 32'h0);
        addr = 32'd4; wrdata = 32'h0BADCAFE; MemWrite = 1'b1;
        at(96); chk("write_after_midcycle_release", rddata, 32'h0BADCAFE);
        MemWrite = 1'b0;

        // Vector table, starting from a freshly cleared array.
        at(100); reset_n = 1'b0;
        at(102); reset_n = 1'b1;
        clear_model();
        vecs[0] = '{1'b1, 1'b0, 32'd7,          32'hAAAA0001, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'd7,          32'h0,        32'hAAAA0001};
        vecs[2] = '{1'b1, 1'b1, 32'd263,        32'hBBBB0002, 32'hAAAA0001};
        vecs[3] = '{1'b0, 1'b1, 32'd7,          32'h0,        32'hBBBB0002};
        vecs[4] = '{1'b0, 1'b0, 32'd7,          32'h0,        32'h0};
        vecs[5] = '{1'b1, 1'b1, 32'd255,        32'hFFFFFFFF, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 32'hFFFFFFFF,   32'h0,        32'hFFFFFFFF};
        vecs[7] = '{1'b0, 1'b1, 32'd0,          32'h0,        32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'd0,          32'h12345678, 32'h0};
        vecs[9] = '{1'b0, 1'b1, 32'h80000100,   32'h0,        32'h12345678};
        for (int v = 0; v < 10; v++) begin
            @(negedge clock);
            MemWrite = vecs[v].we; MemRead = vecs[v].re;
            addr = vecs[v].a; wrdata = vecs[v].wd;
            #1 chk($sformatf("vec%0d", v), rddata, vecs[v].exp_rd);
            @(posedge clock);
            if (vecs[v].we) model[vecs[v].a % DEPTH] = vecs[v].wd;
        end

        // Randomized traffic: narrow index range to force hits, random upper bits for aliasing.
        for (int r = 0; r < 400; r++) begin
            @(negedge clock);
            MemWrite = ($urandom_range(0, 2) == 0);
            MemRead  = ($urandom_range(0, 3) != 0);
            addr     = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
            wrdata   = $urandom;
            #1 chk("rand_pre_edge", rddata, ref_read(MemRead, addr));
            @(posedge clock);
            if (MemWrite) model[addr % DEPTH] = wrdata;
            #1 chk("rand_post_edge", rddata, ref_read(MemRead, addr));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
